// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response codes and channel FSM state types
// for the SRAM-backed bus slave.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } w_state_t;

endpackage

// File: rtl/sram_byte_mem.sv
// Word-wide SRAM with one synchronous read port and one byte-enabled
// write port; same-address collisions return the pre-write data.
module sram_byte_mem #(
    parameter int DEPTH_WORDS = 4096,
    parameter int DATA_W      = 64
) (
    input  logic                           clk,
    input  logic                           rd_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] rd_addr,
    output logic [DATA_W-1:0]              rd_data,
    input  logic                           wr_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] wr_addr,
    input  logic [DATA_W/8-1:0]            wr_be,
    input  logic [DATA_W-1:0]              wr_data
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Non-blocking update gives read-before-write on a shared edge
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
        if (wr_en) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axi4_lite_sram_slave.sv
// AXI4-Lite slave over a byte-strobed SRAM; independent read and
// write channel FSMs with programmable response latency.
module axi4_lite_sram_slave
    import axi4_lite_pkg::*;
#(
    parameter int                ADDR_W      = 64,
    parameter int                DATA_W      = 64,
    parameter int                DEPTH_WORDS = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 64'h8000_0000,
    parameter int                RD_LATENCY  = 2,
    parameter int                WR_LATENCY  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   ar_addr,
    input  logic                ar_valid,
    input  logic [2:0]          ar_prot,
    output logic                ar_ready,
    output logic [DATA_W-1:0]   r_data,
    output logic [1:0]          r_resp,
    output logic                r_valid,
    input  logic                r_ready,
    input  logic [ADDR_W-1:0]   aw_addr,
    input  logic                aw_valid,
    input  logic [2:0]          aw_prot,
    output logic                aw_ready,
    input  logic [DATA_W-1:0]   w_data,
    input  logic [DATA_W/8-1:0] w_strb,
    input  logic                w_valid,
    output logic                w_ready,
    output logic [1:0]          b_resp,
    output logic                b_valid,
    input  logic                b_ready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IW     = $clog2(DEPTH_WORDS);
    localparam int OW     = $clog2(STRB_W);
    localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(DEPTH_WORDS * STRB_W);

    function automatic logic hit(input logic [ADDR_W-1:0] a);
        return (a >= BASE_ADDR) && ((a - BASE_ADDR) < SPAN);
    endfunction

    function automatic logic [IW-1:0] word(input logic [ADDR_W-1:0] a);
        return IW'((a - BASE_ADDR) >> OW);
    endfunction

    logic unused;
    assign unused = ^{ar_prot, aw_prot};

    // ---------------- read channel ----------------
    r_state_t    r_state, r_next;
    logic [7:0]  r_cnt, r_cnt_next;
    logic [IW-1:0] r_idx;
    logic        r_err, r_err_now, r_sample, ar_hs;
    logic [IW-1:0] rd_addr;
    logic [DATA_W-1:0] mem_q;

    assign ar_hs     = ar_valid & ar_ready;
    assign r_err_now = (r_state == R_IDLE) ? !hit(ar_addr) : r_err;
    assign rd_addr   = (r_state == R_IDLE) ? word(ar_addr) : r_idx;
    assign r_data    = (r_valid && r_resp == RESP_OKAY) ? mem_q : '0;

    always_comb begin
        r_next     = r_state;
        r_cnt_next = r_cnt;
        r_sample   = 1'b0;
        unique case (r_state)
            R_IDLE: if (ar_hs) begin
                r_cnt_next = 8'(RD_LATENCY - 1);
                r_next     = (RD_LATENCY == 1) ? R_RESP : R_WAIT;
                r_sample   = (RD_LATENCY == 1);
            end
            R_WAIT: if (r_cnt == '0) begin
                r_next   = R_RESP;
                r_sample = 1'b1;
            end else begin
                r_cnt_next = r_cnt - 8'd1;
            end
            R_RESP: if (r_ready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= R_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_err    <= 1'b0;
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_resp   <= RESP_OKAY;
        end else begin
            r_state  <= r_next;
            r_cnt    <= r_cnt_next;
            ar_ready <= (r_next == R_IDLE);
            r_valid  <= (r_next == R_RESP);
            if (ar_hs) begin
                r_idx <= word(ar_addr);
                r_err <= !hit(ar_addr);
            end
            if (r_sample) r_resp <= r_err_now ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // ---------------- write channel ----------------
    w_state_t    w_state, w_next;
    logic [7:0]  w_cnt, w_cnt_next;
    logic        aw_got, w_got, aw_got_next, w_got_next;
    logic        aw_hs, w_hs, have_aw, have_w, commit;
    logic [IW-1:0]     w_idx, c_idx;
    logic              w_err, c_err;
    logic [DATA_W-1:0] wd_q, c_data;
    logic [STRB_W-1:0] ws_q, c_strb;

    assign aw_hs   = aw_valid & aw_ready;
    assign w_hs    = w_valid & w_ready;
    assign have_aw = aw_got | aw_hs;
    assign have_w  = w_got | w_hs;
    // Latched payload once held, else the live bus (single-cycle latency)
    assign c_idx   = aw_got ? w_idx : word(aw_addr);
    assign c_err   = aw_got ? w_err : !hit(aw_addr);
    assign c_data  = w_got ? wd_q : w_data;
    assign c_strb  = w_got ? ws_q : w_strb;

    always_comb begin
        w_next      = w_state;
        w_cnt_next  = w_cnt;
        commit      = 1'b0;
        aw_got_next = have_aw;
        w_got_next  = have_w;
        unique case (w_state)
            W_IDLE: if (have_aw && have_w) begin
                w_cnt_next = 8'(WR_LATENCY - 1);
                commit     = (WR_LATENCY == 1);
                w_next     = (WR_LATENCY == 1) ? W_RESP : W_WAIT;
            end
            W_WAIT: if (w_cnt == '0) begin
                commit = 1'b1;
                w_next = W_RESP;
            end else begin
                w_cnt_next = w_cnt - 8'd1;
            end
            W_RESP: if (b_ready) begin
                w_next      = W_IDLE;
                aw_got_next = 1'b0;
                w_got_next  = 1'b0;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state  <= W_IDLE;
            w_cnt    <= '0;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            w_idx    <= '0;
            w_err    <= 1'b0;
            wd_q     <= '0;
            ws_q     <= '0;
            aw_ready <= 1'b0;
            w_ready  <= 1'b0;
            b_valid  <= 1'b0;
            b_resp   <= RESP_OKAY;
        end else begin
            w_state  <= w_next;
            w_cnt    <= w_cnt_next;
            aw_got   <= aw_got_next;
            w_got    <= w_got_next;
            aw_ready <= (w_next == W_IDLE) && !aw_got_next;
            w_ready  <= (w_next == W_IDLE) && !w_got_next;
            b_valid  <= (w_next == W_RESP);
            if (aw_hs) begin
                w_idx <= word(aw_addr);
                w_err <= !hit(aw_addr);
            end
            if (w_hs) begin
                wd_q <= w_data;
                ws_q <= w_strb;
            end
            if (commit) b_resp <= c_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    sram_byte_mem #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_W      (DATA_W)
    ) u_mem (
        .clk     (clk),
        .rd_en   (r_sample),
        .rd_addr (rd_addr),
        .rd_data (mem_q),
        .wr_en   (commit && !c_err),
        .wr_addr (c_idx),
        .wr_be   (c_strb),
        .wr_data (c_data)
    );

endmodule

// File: tb/tb_axi4_lite_sram_slave.sv
// Directed bench for axi4_lite_sram_slave: latency, strobes, range
// errors, back-pressure, collisions and mid-transaction reset.
module tb_axi4_lite_sram_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] ar_addr, aw_addr, w_data, r_data;
    logic        ar_valid, ar_ready, r_valid, r_ready;
    logic        aw_valid, aw_ready, w_valid, w_ready;
    logic        b_valid, b_ready;
    logic [2:0]  ar_prot, aw_prot;
    logic [7:0]  w_strb;
    logic [1:0]  r_resp, b_resp;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam logic [63:0] W0   = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] W4   = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] W6   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] PAT  = 64'h1111_2222_3333_4444;

    always #5 clk = ~clk;

    axi4_lite_sram_slave dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ar_addr  (ar_addr),
        .ar_valid (ar_valid),
        .ar_prot  (ar_prot),
        .ar_ready (ar_ready),
        .r_data   (r_data),
        .r_resp   (r_resp),
        .r_valid  (r_valid),
        .r_ready  (r_ready),
        .aw_addr  (aw_addr),
        .aw_valid (aw_valid),
        .aw_prot  (aw_prot),
        .aw_ready (aw_ready),
        .w_data   (w_data),
        .w_strb   (w_strb),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .b_resp   (b_resp),
        .b_valid  (b_valid),
        .b_ready  (b_ready)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; hold = cycles r_ready stays low once r_valid
    task automatic rd(input logic [63:0] a, input int hold,
                      output logic [63:0] d, output logic [1:0] rs,
                      output int lat);
        int n;
        ar_addr  = a;
        ar_valid = 1'b1;
        r_ready  = 1'b0;
        n = 0;
        while (!ar_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        ar_valid = 1'b0;
        lat = 0;
        while (!r_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        d  = r_data;
        rs = r_resp;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_r_valid", r_valid, 1);
            check("bp_r_data", r_data, d);
            check("bp_r_resp", r_resp, rs);
            check("bp_ar_ready", ar_ready, 0);
        end
        r_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r_ready = 1'b0;
        check("r_valid_drop", r_valid, 0);
    endtask

    // AW and W raised after awd / wd cycles respectively
    task automatic wr(input logic [63:0] a, input logic [63:0] d,
                      input logic [7:0] s, input int awd, input int wd,
                      output logic [1:0] rs, output int lat);
        int  k;
        logic aw_done, w_done, aw_hs, w_hs;
        k = 0;
        aw_done = 1'b0;
        w_done  = 1'b0;
        while (!(aw_done && w_done) && k < 50) begin
            if (k == awd) begin
                aw_addr  = a;
                aw_valid = 1'b1;
            end
            if (k == wd) begin
                w_data  = d;
                w_strb  = s;
                w_valid = 1'b1;
            end
            aw_hs = aw_valid && aw_ready;
            w_hs  = w_valid && w_ready;
            @(posedge clk);
            @(negedge clk);
            if (aw_hs) begin
                aw_done  = 1'b1;
                aw_valid = 1'b0;
            end
            if (w_hs) begin
                w_done  = 1'b1;
                w_valid = 1'b0;
            end
            k++;
        end
        lat = 0;
        while (!b_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rs = b_resp;
        b_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] d, d2;
        logic [1:0]  rs, rs2;
        int          lat, lat2, n;
        logic [63:0] pre [8];
        int          ord [3][2];

        pre = '{W0, 64'h0, 64'h0, 64'h0, W4, 64'h0, W6, 64'h0};
        ord = '{'{0, 2}, '{2, 0}, '{0, 0}};

        rst_n = 1'b0;
        {ar_valid, r_ready, aw_valid, w_valid, b_ready} = '0;
        ar_addr = '0; aw_addr = '0; w_data = '0; w_strb = '0;
        ar_prot = '0; aw_prot = '0;

        repeat (3) @(negedge clk);
        check("rst_ar_ready", ar_ready, 0);
        check("rst_aw_w_ready", {aw_ready, w_ready}, 0);
        check("rst_valids", {r_valid, b_valid}, 0);
        check("rst_data_resp", {r_data, r_resp, b_resp}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ar_ready_rise", ar_ready, 1);
        check("aw_w_ready_rise", {aw_ready, w_ready}, 2'b11);

        for (int i = 0; i < 8; i++) wr(BASE + 64'(i * 8), pre[i], 8'hFF, 0, 0, rs, lat);

        rd(BASE, 0, d, rs, lat);
        check("rd0_data", d, W0);
        check("rd0_resp", rs, 0);
        check("rd0_lat", lat, 2);

        for (int i = 0; i < 3; i++) begin
            wr(BASE + 64'((i + 1) * 8), PAT, 8'h0F, ord[i][0], ord[i][1], rs, lat);
            check("wr_ord_resp", rs, 0);
            check("wr_ord_lat", lat, 2);
            rd(BASE + 64'((i + 1) * 8), 0, d, rs, lat);
            check("wr_ord_data", d, 64'h0000_0000_3333_4444);
        end

        wr(BASE + 64'h28, PAT, 8'hF0, 0, 0, rs, lat);
        rd(BASE + 64'h28, 0, d, rs, lat);
        check("strb_hi_data", d, 64'h1111_2222_0000_0000);

        wr(BASE, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, 0, rs, lat);
        check("strb0_resp", rs, 0);
        rd(BASE, 0, d, rs, lat);
        check("strb0_data", d, W0);

        rd(64'h7FFF_FFF8, 0, d, rs, lat);
        check("oor_lo_resp", rs, 2);
        check("oor_lo_data", d, 0);
        rd(64'h8000_8000, 0, d, rs, lat);
        check("oor_hi_rd_resp", rs, 2);
        wr(64'h8000_8000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0, rs, lat);
        check("oor_wr_resp", rs, 2);
        check("oor_wr_lat", lat, 2);
        rd(BASE, 0, d, rs, lat);
        check("oor_word0_kept", d, W0);

        rd(BASE + 64'h30, 5, d, rs, lat);
        check("bp_data", d, W6);

        fork
            rd(BASE + 64'h20, 0, d, rs, lat);
            wr(BASE + 64'h20, 64'h5555_5555_5555_5555, 8'hFF, 0, 0, rs2, lat2);
        join
        check("coll_old", d, W4);
        rd(BASE + 64'h20, 0, d, rs, lat);
        check("coll_new", d, 64'h5555_5555_5555_5555);

        // Reset while the write waits for its commit
        aw_addr = BASE + 64'h30; w_data = PAT; w_strb = 8'hFF;
        aw_valid = 1'b1; w_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        aw_valid = 1'b0; w_valid = 1'b0;
        rst_n = 1'b0;
        n = 0;
        repeat (3) begin
            @(negedge clk);
            n += int'(b_valid);
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            n += int'(b_valid);
        end
        check("wwait_rst_no_b", n, 0);
        rd(BASE + 64'h30, 0, d, rs, lat);
        check("wwait_rst_word", d, W6);

        // Reset while a read response is pending
        ar_addr = BASE; ar_valid = 1'b1; r_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ar_valid = 1'b0;
        n = 0;
        while (!r_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rresp_pre_valid", r_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rresp_rst_valid", r_valid, 0);
        check("rresp_rst_data", r_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rresp_rst_ar_ready", ar_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi4_lite_sram_slave.md
Name: axi4_lite_sram_slave

Overview:
- AXI4-Lite memory slave on the slave side of the AXI4 interconnect; consumes the arbitrated IFU/MEM read and write traffic.
- Backs a word-addressed SRAM with byte strobes.
- Read and write channels run independent FSMs, each with a programmable response latency, so master handshake timing is exercised.
- Gives the core its first real bus endpoint for instruction fetch and load/store.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width; STRB_W = DATA_W/8.
- DEPTH_WORDS, 4096, number of DATA_W words.
- BASE_ADDR, 64'h8000_0000, first mapped byte address.
- RD_LATENCY, 2, cycles from AR handshake to r_valid (min 1).
- WR_LATENCY, 2, cycles from last of AW/W handshake to b_valid (min 1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ar_addr  in  ADDR_W  read address
- ar_valid  in  1  read address valid
- ar_prot  in  3  ignored
- ar_ready  out  1  read address ready
- r_data  out  DATA_W  read data
- r_resp  out  2  read response
- r_valid  out  1  read data valid
- r_ready  in  1  master accepts read data
- aw_addr  in  ADDR_W  write address
- aw_valid  in  1  write address valid
- aw_prot  in  3  ignored
- aw_ready  out  1  write address ready
- w_data  in  DATA_W  write data
- w_strb  in  STRB_W  byte enables
- w_valid  in  1  write data valid
- w_ready  out  1  write data ready
- b_resp  out  2  write response
- b_valid  out  1  write response valid
- b_ready  in  1  master accepts response

Behaviour:
- Reset, asynchronous on rst_n low:
  - All outputs are 0: ar_ready, aw_ready, w_ready, r_valid, b_valid, r_data, r_resp, b_resp.
  - Both FSMs go to IDLE and counters clear.
  - SRAM contents are not cleared.
  - Readies rise on the first clk edge after rst_n goes high.
- Reset mid-transaction: the in-flight transaction is dropped with no response and no partial write.
- Address decode:
  - idx = (addr - BASE_ADDR) >> log2(STRB_W); the low offset bits are ignored.
  - In range iff BASE_ADDR <= addr < BASE_ADDR + DEPTH_WORDS*STRB_W.
- Read FSM, R_IDLE -> R_WAIT -> R_RESP:
  - R_IDLE: ar_ready=1. On ar_valid&ar_ready, latch the address, load cnt=RD_LATENCY-1, drop ar_ready, go to R_WAIT (go straight to R_RESP if RD_LATENCY=1).
  - R_WAIT: decrement cnt. At cnt==0, sample the SRAM into r_data, set r_resp, assert r_valid, go to R_RESP.
  - Net timing: r_valid is first high exactly RD_LATENCY cycles after the AR handshake edge.
  - R_RESP: hold r_valid, r_data and r_resp stable until r_ready. On r_valid&r_ready, drop r_valid and go to R_IDLE with ar_ready=1 on the next cycle. Only one read is outstanding at a time.
  - Out-of-range read: r_resp=SLVERR (2'b10), r_data=0.
- Write FSM, W_IDLE -> W_WAIT -> W_RESP:
  - W_IDLE: aw_ready=1 and w_ready=1, handshaked independently in either order or in the same cycle.
  - Each accepted channel latches its payload and drops its own ready.
  - When both are held, load cnt=WR_LATENCY-1 and go to W_WAIT.
  - W_WAIT, at cnt==0:
    - Commit to the SRAM only the bytes whose w_strb bit is 1.
    - w_strb=0 is a legal no-op that still returns OKAY.
    - Out-of-range address: no commit, b_resp=SLVERR.
    - Assert b_valid and go to W_RESP.
  - W_RESP: hold until b_ready. Then W_IDLE, with both readies high the next cycle.
- Read/write collision: if a read sample and a write commit hit the same word in the same cycle, the read returns the old data (read-before-write). A read sampled on any later cycle sees the new data.
- The read and write FSMs never stall each other.
- Back-pressure: r_ready or b_ready low for any number of cycles is legal; outputs stay stable throughout.

Decomposition:
- Package axi4_lite_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Read-state enum (R_IDLE, R_WAIT, R_RESP) and write-state enum (W_IDLE, W_WAIT, W_RESP).
- One sub-module: sram_byte_mem.
  - Parameterised DEPTH_WORDS/DATA_W.
  - One synchronous read port and one write port with per-byte enable.
  - Read-before-write on same-address collision.

Test Plan:
- Reset then read: rst_n low 3 cycles. Read 0x8000_0000 after a backdoor preload of 64'hDEAD_BEEF_0123_4567 -> ar_ready=1 one cycle after release; r_valid exactly 2 cycles after the AR handshake; r_data matches; r_resp=0.
- Write ordering: AW at 0x8000_0008 two cycles before W (data 64'h1111_2222_3333_4444, strb 8'h0F); repeat with W before AW; repeat with both in the same cycle. Read back -> 64'h0000_0000_3333_4444 from a zeroed word; b_valid 2 cycles after the second handshake each time.
- Out of range: read 0x7FFF_FFF8 -> SLVERR, data 0. Write 0x8000_8000 (DEPTH 4096) -> SLVERR, and a subsequent read of word 0 is unchanged.
- Back-pressure: hold r_ready=0 for 5 cycles -> r_valid, r_data and r_resp stable; ar_ready stays 0 until the r handshake.
- Collision: read of word 4 sampled in the same cycle the write to word 4 commits -> old value returned; a following read returns the new value.
- Mid-transaction reset: pull rst_n low during W_WAIT -> b_valid never asserts and the target word is unmodified. Pull rst_n low during R_RESP -> r_valid drops immediately (asynchronously).
